// File: rtl/wb_spram_pkg.sv
// Shared types and helpers for the Wishbone-to-single-port-RAM bridge.
package wb_spram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // One extra bit keeps the window compare from wrapping at the top of the address space.
    localparam int CMP_W = 33;

    function automatic logic [31:0] word_index(input logic [31:0] adr, input logic [31:0] base);
        return (adr - base) >> 2;
    endfunction

endpackage

// File: rtl/wb_spram_if.sv
// Wishbone B4 pipelined bus bundle between interconnect (master) and RAM port (slave).
interface wb_spram_if;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        input  wb_dat_o, wb_ack, wb_err, wb_stall
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_i,
        output wb_dat_o, wb_ack, wb_err, wb_stall
    );
endinterface

// File: rtl/wb_spram_port.sv
// Wishbone B4 pipelined slave driving a 1-cycle-latency single-port RAM, with optional wait states.
//   state | meaning
//   IDLE  | ready; a beat may be accepted and its RAM strobe issued
//   BUSY  | counting wait states; first cycle captures RAM read data
//   RESP  | drive ack or err for one cycle, then back to IDLE
module wb_spram_port
    import wb_spram_pkg::*;
#(
    parameter logic [31:0] BASE        = 32'h0000_0000,
    parameter int          SIZE        = 'h80,
    parameter int          AW          = $clog2(SIZE) - 2,
    parameter int          WAIT_STATES = 0
) (
    input  logic          clk,
    input  logic          rst,
    wb_spram_if.slave     wb,
    output logic [AW-1:0] ram_addr,
    output logic          ram_ce,
    output logic [3:0]    ram_we,
    output logic [31:0]   ram_d,
    input  logic [31:0]   ram_q
);

    logic             accept;
    logic             in_range;
    logic [CMP_W-1:0] offset;
    logic [31:0]      word_idx;
    logic             unused_word_bits;

    logic             stall;
    logic             ack;
    logic             err;
    logic [31:0]      dat_o;

    assign offset   = {1'b0, wb.wb_adr} - {1'b0, BASE};
    assign in_range = ({1'b0, wb.wb_adr} >= {1'b0, BASE}) && (offset < CMP_W'(SIZE));
    assign accept   = wb.wb_cyc & wb.wb_stb & ~stall & ~rst;

    assign word_idx         = word_index(wb.wb_adr, BASE);
    assign ram_addr         = word_idx[AW-1:0];
    assign unused_word_bits = ^word_idx[31:AW];

    assign ram_ce = accept & in_range;
    assign ram_we = ram_ce ? (wb.wb_sel & {4{wb.wb_we}}) : 4'h0;
    assign ram_d  = wb.wb_dat_i;

    generate
        if (WAIT_STATES == 0) begin : g_pipe
            logic ack_q;
            logic err_q;
            logic rd_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    rd_q  <= 1'b0;
                end else begin
                    ack_q <= accept & in_range;
                    err_q <= accept & ~in_range;
                    rd_q  <= accept & in_range & ~wb.wb_we;
                end
            end

            // Dropping cyc masks the response that is due this cycle.
            assign stall = 1'b0;
            assign ack   = ack_q & wb.wb_cyc;
            assign err   = err_q & wb.wb_cyc;
            assign dat_o = (ack && rd_q) ? ram_q : 32'h0;
        end else begin : g_wait
            localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

            state_t        state;
            state_t        state_nxt;
            logic [CW-1:0] cnt;
            logic [CW-1:0] cnt_nxt;
            logic          in_range_q;
            logic          we_q;
            logic          fresh_q;
            logic [31:0]   hold;

            always_ff @(posedge clk) begin
                if (rst) begin
                    state      <= IDLE;
                    cnt        <= '0;
                    in_range_q <= 1'b0;
                    we_q       <= 1'b0;
                    fresh_q    <= 1'b0;
                    hold       <= 32'h0;
                end else begin
                    state   <= state_nxt;
                    cnt     <= cnt_nxt;
                    fresh_q <= accept;
                    if (accept) begin
                        in_range_q <= in_range;
                        we_q       <= wb.wb_we;
                    end
                    // RAM output is only valid in the cycle right after the strobe.
                    if (fresh_q) begin
                        hold <= (in_range_q && !we_q) ? ram_q : 32'h0;
                    end
                end
            end

            always_comb begin
                state_nxt = state;
                cnt_nxt   = cnt;
                stall     = 1'b0;
                ack       = 1'b0;
                err       = 1'b0;
                case (state)
                    IDLE: begin
                        if (accept) begin
                            state_nxt = BUSY;
                            cnt_nxt   = CW'(WAIT_STATES - 1);
                        end
                    end
                    BUSY: begin
                        stall = 1'b1;
                        if (cnt == '0) begin
                            state_nxt = RESP;
                        end else begin
                            cnt_nxt = cnt - CW'(1);
                        end
                    end
                    RESP: begin
                        stall     = 1'b1;
                        ack       = wb.wb_cyc & in_range_q;
                        err       = wb.wb_cyc & ~in_range_q;
                        state_nxt = IDLE;
                    end
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase
                if (!wb.wb_cyc) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end

            assign dat_o = ack ? hold : 32'h0;
        end
    endgenerate

    assign wb.wb_stall = stall;
    assign wb.wb_ack   = ack;
    assign wb.wb_err   = err;
    assign wb.wb_dat_o = dat_o;

endmodule

// File: tb/tb_wb_spram_port.sv
// Directed bench: four bridge instances (pipelined, offset window, 3 and 2 wait states) each with a RAM model.
module tb_wb_spram_port;

    logic        clk;
    logic        rst;
    logic [1:0]  dsel;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;

    logic [3:0]  ack_v;
    logic [3:0]  err_v;
    logic [3:0]  stall_v;
    logic [3:0]  ce_v;
    logic [3:0]  we_v   [4];
    logic [4:0]  addr_v [4];
    logic [31:0] dat_v  [4];

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wb_spram_if bus ();
        logic [4:0]  ram_addr;
        logic        ram_ce;
        logic [3:0]  ram_we;
        logic [31:0] ram_d;
        logic [31:0] ram_q;
        logic [31:0] mem [32];
        logic [31:0] mask;

        assign bus.wb_cyc   = cyc & (dsel == 2'(g));
        assign bus.wb_stb   = stb & (dsel == 2'(g));
        assign bus.wb_we    = we;
        assign bus.wb_sel   = sel;
        assign bus.wb_adr   = adr;
        assign bus.wb_dat_i = wdat;

        wb_spram_port #(
            .BASE        ((g == 1) ? 32'h0000_1000 : 32'h0000_0000),
            .SIZE        ('h80),
            .WAIT_STATES ((g == 2) ? 3 : ((g == 3) ? 2 : 0))
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .wb       (bus),
            .ram_addr (ram_addr),
            .ram_ce   (ram_ce),
            .ram_we   (ram_we),
            .ram_d    (ram_d),
            .ram_q    (ram_q)
        );

        assign mask = {{8{ram_we[3]}}, {8{ram_we[2]}}, {8{ram_we[1]}}, {8{ram_we[0]}}};

        always @(posedge clk) begin
            if (ram_ce) begin
                mem[ram_addr] <= (mem[ram_addr] & ~mask) | (ram_d & mask);
                ram_q         <= mem[ram_addr];
            end
        end

        assign ack_v[g]   = bus.wb_ack;
        assign err_v[g]   = bus.wb_err;
        assign stall_v[g] = bus.wb_stall;
        assign ce_v[g]    = ram_ce;
        assign we_v[g]    = ram_we;
        assign addr_v[g]  = ram_addr;
        assign dat_v[g]   = bus.wb_dat_o;
    end

    logic        ack_m, err_m, stall_m, ce_m;
    logic [3:0]  we_m;
    logic [4:0]  addr_m;
    logic [31:0] dat_m;

    assign ack_m   = ack_v[dsel];
    assign err_m   = err_v[dsel];
    assign stall_m = stall_v[dsel];
    assign ce_m    = ce_v[dsel];
    assign we_m    = we_v[dsel];
    assign addr_m  = addr_v[dsel];
    assign dat_m   = dat_v[dsel];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive just after the rising edge, return at the falling edge for sampling.
    task automatic cycle(input logic r, input logic c, input logic s, input logic w,
                         input logic [3:0] bs, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst  = r;
        cyc  = c;
        stb  = s;
        we   = w;
        sel  = bs;
        adr  = a;
        wdat = d;
        @(negedge clk);
    endtask

    task automatic hold_cyc();
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; dsel = 2'd0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; adr = 32'h0; wdat = 32'h0;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("rst_ack", 32'(ack_m), 32'h0);
        check("rst_err", 32'(err_m), 32'h0);
        check("rst_stall", 32'(stall_m), 32'h0);
        check("rst_dat", dat_m, 32'h0);
        check("rst_ce", 32'(ce_m), 32'h0);
        check("rst_we", 32'(we_m), 32'h0);
        dsel = 2'd2;
        #1;
        check("rst_stall_ws", 32'(stall_m), 32'h0);
        dsel = 2'd0;
        idle();

        // Pipelined write then read-after-write
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        check("p_wr_ce", 32'(ce_m), 32'h1);
        check("p_wr_we", 32'(we_m), 32'hF);
        check("p_wr_addr", 32'(addr_m), 32'h4);
        check("p_wr_stall", 32'(stall_m), 32'h0);
        check("p_wr_ack_early", 32'(ack_m), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        check("p_wr_ack", 32'(ack_m), 32'h1);
        check("p_wr_dat", dat_m, 32'h0);
        check("p_rd_ce", 32'(ce_m), 32'h1);
        check("p_rd_we", 32'(we_m), 32'h0);
        hold_cyc();
        check("p_rd_ack", 32'(ack_m), 32'h1);
        check("p_rd_dat", dat_m, 32'hDEAD_BEEF);
        check("p_rd_stall", 32'(stall_m), 32'h0);

        // Byte lanes, then a sel=0 write that must still strobe and ack
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 32'h10, 32'h1122_3344);
        check("bl_we", 32'(we_m), 32'h5);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h14, 32'h5555_5555);
        check("bl_ack", 32'(ack_m), 32'h1);
        check("sel0_ce", 32'(ce_m), 32'h1);
        check("sel0_we", 32'(we_m), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        check("sel0_ack", 32'(ack_m), 32'h1);
        hold_cyc();
        check("bl_rd_dat", dat_m, 32'hDE22_BE44);
        idle();
        check("idle_ack", 32'(ack_m), 32'h0);

        // Range checks on the window at 0x1000
        dsel = 2'd1;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h107C, 32'hCAFE_F00D);
        check("r_wr_ce", 32'(ce_m), 32'h1);
        check("r_wr_addr", 32'(addr_m), 32'h1F);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h1080, 32'h0);
        check("r_wr_ack", 32'(ack_m), 32'h1);
        check("r_1080_ce", 32'(ce_m), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0FFC, 32'h0);
        check("r_1080_err", 32'(err_m), 32'h1);
        check("r_1080_ack", 32'(ack_m), 32'h0);
        check("r_1080_dat", dat_m, 32'h0);
        check("r_0ffc_ce", 32'(ce_m), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h107C, 32'h0);
        check("r_0ffc_err", 32'(err_m), 32'h1);
        check("r_0ffc_ack", 32'(ack_m), 32'h0);
        check("r_107c_ce", 32'(ce_m), 32'h1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0);
        check("r_107c_ack", 32'(ack_m), 32'h1);
        check("r_107c_err", 32'(err_m), 32'h0);
        check("r_107c_dat", dat_m, 32'hCAFE_F00D);
        check("r_top_ce", 32'(ce_m), 32'h0);
        hold_cyc();
        check("r_top_err", 32'(err_m), 32'h1);
        check("r_top_dat", dat_m, 32'h0);
        idle();

        // Three wait states: write, then read with a second strobe held through the stall
        dsel = 2'd2;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h20, 32'h1234_5678);
        check("w3_wr_ce", 32'(ce_m), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            hold_cyc();
            check("w3_wr_wait_ack", 32'(ack_m), 32'h0);
        end
        hold_cyc();
        check("w3_wr_ack", 32'(ack_m), 32'h1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        check("w3_rd_ce", 32'(ce_m), 32'h1);
        check("w3_rd_stall0", 32'(stall_m), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
            check("w3_busy_stall", 32'(stall_m), 32'h1);
            check("w3_busy_ack", 32'(ack_m), 32'h0);
            check("w3_busy_ce", 32'(ce_m), 32'h0);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        check("w3_resp_stall", 32'(stall_m), 32'h1);
        check("w3_resp_ack", 32'(ack_m), 32'h1);
        check("w3_resp_dat", dat_m, 32'h1234_5678);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        check("w3_2nd_stall", 32'(stall_m), 32'h0);
        check("w3_2nd_ce", 32'(ce_m), 32'h1);
        check("w3_2nd_ack", 32'(ack_m), 32'h0);
        for (int i = 1; i <= 3; i++) hold_cyc();
        hold_cyc();
        check("w3_2nd_resp_ack", 32'(ack_m), 32'h1);
        check("w3_2nd_resp_dat", dat_m, 32'h1234_5678);

        // Reset while BUSY
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        check("rb_ce", 32'(ce_m), 32'h1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        hold_cyc();
        check("rb_ack", 32'(ack_m), 32'h0);
        check("rb_err", 32'(err_m), 32'h0);
        check("rb_stall", 32'(stall_m), 32'h0);
        check("rb_ce_idle", 32'(ce_m), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        check("rb_new_ce", 32'(ce_m), 32'h1);
        for (int i = 1; i <= 3; i++) begin
            hold_cyc();
            check("rb_new_wait_ack", 32'(ack_m), 32'h0);
        end
        hold_cyc();
        check("rb_new_ack", 32'(ack_m), 32'h1);
        check("rb_new_dat", dat_m, 32'h1234_5678);
        idle();

        // Abort with two wait states
        dsel = 2'd3;
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'hF, 32'h30, 32'hA5A5_5A5A);
        check("ab_ce", 32'(ce_m), 32'h1);
        check("ab_we", 32'(we_m), 32'hF);
        idle();
        check("ab_t1_ack", 32'(ack_m), 32'h0);
        check("ab_t1_err", 32'(err_m), 32'h0);
        hold_cyc();
        check("ab_t2_stall", 32'(stall_m), 32'h0);
        check("ab_t2_ack", 32'(ack_m), 32'h0);
        hold_cyc();
        check("ab_t3_ack", 32'(ack_m), 32'h0);
        check("ab_t3_err", 32'(err_m), 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
        check("ab_rd_ce", 32'(ce_m), 32'h1);
        hold_cyc();
        check("ab_rd_stall1", 32'(stall_m), 32'h1);
        hold_cyc();
        check("ab_rd_wait_ack", 32'(ack_m), 32'h0);
        hold_cyc();
        check("ab_rd_ack", 32'(ack_m), 32'h1);
        check("ab_rd_dat", dat_m, 32'hA5A5_5A5A);
        idle();
        check("ab_end_ack", 32'(ack_m), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_spram_port.md
Name: wb_spram_port

Overview:
- Wishbone B4 pipelined slave that acts as the initiator for a single-port 32-bit synchronous RAM port (addr/ce/we[3:0]/d/q, 1-cycle read latency, byte write enables).
- Converts bus beats into RAM strobes, returns read data with ack, and flags out-of-range accesses with err.
- Sits between the SoC interconnect and each on-chip instruction/data RAM instance.
- Optional wait states make slow-memory timing reproducible in simulation.

Parameters:
- BASE, 32'h0000_0000, byte base address of the RAM window.
- SIZE, 'h80, window size in bytes; power of two, at least 8.
- AW, $clog2(SIZE)-2, RAM word-address width.
- WAIT_STATES, 0, extra response cycles per beat. 0 selects fully pipelined operation.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- wb_cyc  in  1  bus cycle
- wb_stb  in  1  strobe
- wb_we  in  1  write
- wb_sel  in  4  byte selects
- wb_adr  in  32  byte address
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data
- wb_ack  out  1  normal termination
- wb_err  out  1  error termination
- wb_stall  out  1  pipeline stall
- ram_addr  out  AW  RAM word address
- ram_ce  out  1  RAM chip enable
- ram_we  out  4  RAM byte write enables
- ram_d  out  32  RAM write data
- ram_q  in  32  RAM read data, valid 1 cycle after ce

Behaviour:
- Clock is clk; reset is rst, synchronous and active high. While rst is high, all inputs are ignored.
- Reset values: wb_ack=0, wb_err=0, wb_stall=0, wb_dat_o=0, ram_ce=0, ram_we=0, state=IDLE, counter=0.
- accept = wb_cyc & wb_stb & !wb_stall & !rst.
- in_range = (wb_adr >= BASE) & (wb_adr - BASE < SIZE), using 33-bit arithmetic so there is no wrap at 32'hFFFF_FFFC.
- wb_adr[1:0] are ignored.
- ram_addr = (wb_adr - BASE)[AW+1:2].
- RAM strobes are combinational, issued in the accept cycle:
  - ram_ce = accept & in_range.
  - ram_we = ram_ce ? (wb_sel & {4{wb_we}}) : 0.
  - ram_d = wb_dat_i.
- Out-of-range beats never assert ram_ce; they terminate with err instead of ack.
- Writes with wb_sel=0 still strobe ce and are acked.
- WAIT_STATES=0 (pipelined):
  - wb_stall is always 0, so one beat can be accepted every cycle.
  - Each accepted beat gets exactly one response in cycle T+1: ack if in range, otherwise err.
  - Read data: wb_dat_o = ram_q in the ack cycle; wb_dat_o = 0 on err and for writes.
  - Back-to-back read-after-write to the same address returns the new data, because the RAM write has already committed at the T+1 edge.
- WAIT_STATES=N>=1 uses FSM IDLE -> BUSY -> RESP -> IDLE.
  - IDLE: wb_stall=0. On accept, issue the RAM strobe, latch in_range and wb_we, load counter=N-1, go to BUSY.
  - BUSY: wb_stall=1. In the first BUSY cycle, capture ram_q into a hold register. Decrement the counter; go to RESP when it reaches 0.
  - RESP: wb_stall=1. Assert ack or err for exactly one cycle with wb_dat_o = hold register; then go to IDLE.
  - Net response cycle is T+1+N. Only one beat is outstanding.
- Abort: wb_cyc low in any cycle clears every pending response, so no ack/err is issued for that beat. The FSM returns to IDLE next cycle. RAM writes already issued stay committed.
- ack and err are never high in the same cycle, and are never high while wb_cyc=0.
- Reset mid-operation: next cycle all outputs take their reset values; any pending response is discarded.

Decomposition:
- Package wb_spram_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - the localparam for the 33-bit range-compare width;
  - the function word_index(adr, base).
- No sub-module. The RAM is instantiated beside this block by the memory wrapper.

Test Plan:
- WAIT_STATES=0, BASE=0, SIZE='h80: write adr 0x10, sel 4'hF, data 0xDEADBEEF, then read 0x10 the following cycle -> ack at T+1 for each beat, read returns 0xDEADBEEF, wb_stall stays 0.
- Byte lanes: write 0x11223344 with sel 4'h5 over prior 0xDEADBEEF -> ram_we=4'h5, later read returns 0xDE22BE44.
- Range: BASE=32'h1000, read adr 0x1080 and 0x0FFC -> err at T+1, no ack, ram_ce never asserted, wb_dat_o=0; adr 0x107C -> ack.
- WAIT_STATES=3: read issued at T -> stall high T+1..T+4, ack only at T+4 with correct data; a second stb held during the stall is accepted at T+5.
- Abort: WAIT_STATES=2, write accepted, wb_cyc dropped at T+1 -> no ack/err ever seen, FSM IDLE at T+2, and a later read confirms the write committed.
- Reset: assert rst during BUSY -> next cycle ack=err=stall=0, ram_ce=0; the first beat after rst releases completes normally.
